seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Parametrised successor to the single-digit 7-segment decoder.
- Drives a multi-digit, time-multiplexed 7-segment display from a packed hex value.
- Contains a scan prescaler, a digit index counter, a shadow value register and registered segment/anode outputs.
- Sits between the core's debug/status registers and the board display pins.

Parameters:
- DIGITS, 4, number of display digits; legal range 1..8.
- SCAN_DIV, 1000, clock cycles each digit stays lit; legal value >=1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  display enable; 0 blanks the display and holds the scan.
- load  input  1  1-cycle strobe; captures value and dp_mask into shadow registers.
- value  input  4*DIGITS  packed hex nibbles; bits [3:0] = digit 0 (rightmost).
- dp_mask  input  DIGITS  decimal-point request per digit; 1 = point on.
- seg  output  7  active-low segments, bit0=a … bit6=g.
- dp  output  1  active-low decimal point.
- an  output  DIGITS  active-low digit select; exactly one bit low while displaying.
- frame_done  output  1  1-cycle pulse each time the scan wraps to digit 0.

Behaviour:
- Reset (rst=1 at clock edge, wins over everything):
  - seg=7'h7F, dp=1, an=all ones, frame_done=0.
  - Prescaler=0, digit index=0, shadow value=0, shadow dp=0.
- Shadow registers:
  - load=1 latches value/dp_mask on that edge, regardless of en.
  - Display always uses the shadow registers, never the live inputs.
- Prescaler:
  - When en=1, it counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 it returns to 0 and the index advances by 1.
  - The index wraps from DIGITS-1 to 0. With SCAN_DIV=1 the index advances every cycle.
- frame_done:
  - Registered; high for exactly the one cycle in which the index holds 0 after a wrap from DIGITS-1.
  - Not asserted at reset exit or at en re-enable.
- Outputs (registered, one-cycle latency from index to pins):
  - an = ~(1<<index).
  - seg = hex encoding of shadow nibble[index].
  - dp = ~shadow_dp[index].
- Hex encoding, gfedcba, active low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- en=0:
  - On the next edge: an=all ones, seg=7'h7F, dp=1, prescaler=0, index=0, frame_done=0.
  - On re-enable, digit 0 appears on the cycle after en returns to 1 and dwells a full SCAN_DIV cycles.
- Simultaneous events:
  - load on a digit-advance edge: the new shadow value is shown from the next output update. No glitch mixes old and new nibbles within one output cycle.
  - rst together with load: reset wins.
- Only one anode is low at any time.
- No combinational path exists from inputs to outputs.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined:
  - Digit i>0 is blanked (seg=7'h7F, dp=1, anode still driven low) when shadow nibble i and all higher nibbles are 0 and shadow_dp[i]=0.
  - Digit 0 is never blanked.
- Undefined: every digit is shown, including leading zeros. Scan timing is identical in both builds.

Test Plan:
- Reset: hold rst 2 cycles with en=1, load=1, value=16'hFFFF -> seg=7'h7F, dp=1, an=4'b1111, frame_done=0. After release (DIGITS=4, SCAN_DIV=4) the first displayed digit shows 0=1000000.
- Scan: load value=16'h12AF, en=1, SCAN_DIV=4:
  - an cycles 1110,1101,1011,0111, 4 cycles each.
  - seg sequence is 0001110, 0001000, 0100100, 1111001.
  - frame_done pulses every 16 cycles.
- Decimal point: dp_mask=4'b0100 -> dp=0 only while an=1011.
- Enable: drop en mid-digit 2 -> the next cycle has an=1111, seg=7'h7F. Re-raise en -> an=1110 one cycle later, dwells 4 cycles, no frame_done.
- Load collision: load 16'h0003 on the edge where the index moves 3->0 -> digit 0 shows 0110000 and frame_done=1 that cycle. Synchronous rst mid-scan -> all outputs are at reset values on the next cycle.
- Leading-zero blanking (macro defined): value=16'h0030, dp_mask=0 -> digits 3,2 seg=7'h7F, digit1=0110000, digit0=1000000. Without the macro, digits 3,2 show 1000000.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
//
// Purpose:
//   Time-multiplexed driver for a DIGITS-wide common-anode 7-segment display.
//   A packed hex value and a per-digit decimal-point mask are captured into
//   shadow registers on 'load'. Each digit is lit for SCAN_DIV clock cycles,
//   and the scan runs from digit 0 (rightmost) up to digit DIGITS-1.
//   All display outputs are registered. No input reaches an output
//   combinationally.
//
// Parameters:
//   DIGITS     number of display digits (1..8)
//   SCAN_DIV   clock cycles each digit stays lit (>= 1)
//
// Ports:
//   clk         system clock; all logic is on the rising edge
//   rst         synchronous active-high reset; it overrides every other input
//   en          display enable; 0 blanks the display and parks the scan
//   load        1-cycle strobe that captures value/dp_mask into the shadows
//   value       packed hex nibbles; bits [3:0] hold digit 0
//   dp_mask     per-digit decimal-point request; 1 turns the point on
//   seg         active-low segments; bit0 = a ... bit6 = g
//   dp          active-low decimal point
//   an          active-low digit select; one-hot low while displaying
//   frame_done  1-cycle pulse when digit 0 is redisplayed after a wrap
//
// Build option:
//   SEG7_LEADING_ZERO_BLANK_EN - when defined, the driver blanks leading zero
//   digits above digit 0 whose decimal point is off. The anode of a blanked
//   digit is still driven, so scan timing is the same in both builds.
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 1000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp_mask,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [DIGITS-1:0]     an,
   output logic                  frame_done
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PS_LAST  = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
   localparam logic [6:0]    SEG_OFF  = 7'h7F;

   logic [PW-1:0]         ps;
   logic [IW-1:0]         idx;
   logic [4*DIGITS-1:0]   shadow_val;
   logic [DIGITS-1:0]     shadow_dp;
   // Set on the edge where the index wraps to 0. It becomes frame_done on the
   // next edge, which is also the edge that first shows digit 0 on the pins.
   logic                  wrap_q;

   logic [3:0]            nibble;
   logic                  digit_dp;
   logic [6:0]            seg_nxt;
   logic                  dp_nxt;
   logic [DIGITS-1:0]     an_nxt;

   // Hex to active-low gfedcba segment pattern.
   function automatic logic [6:0] hex7(input logic [3:0] h);
      case (h)
         4'h0: hex7 = 7'b1000000;
         4'h1: hex7 = 7'b1111001;
         4'h2: hex7 = 7'b0100100;
         4'h3: hex7 = 7'b0110000;
         4'h4: hex7 = 7'b0011001;
         4'h5: hex7 = 7'b0010010;
         4'h6: hex7 = 7'b0000010;
         4'h7: hex7 = 7'b1111000;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0010000;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b0000011;
         4'hC: hex7 = 7'b1000110;
         4'hD: hex7 = 7'b0100001;
         4'hE: hex7 = 7'b0000110;
         default: hex7 = 7'b0001110;
      endcase
   endfunction

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   // zero_from[i] is 1 when nibble i and every nibble above it are zero.
   logic [DIGITS-1:0] zero_from;
   logic              zero_run;
`endif

   // Next pin values for the digit selected by the current index. The pins
   // lag the index by one clock.
   always_comb begin
      // NOTE: every always_comb output gets a default before any branch, so
      // no path can leave a signal unassigned and infer a latch.
      nibble   = shadow_val[4*int'(idx) +: 4];
      digit_dp = shadow_dp[idx];
      seg_nxt  = hex7(nibble);
      dp_nxt   = ~digit_dp;
      an_nxt   = ~(DIGITS'(1) << idx);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      zero_from = '0;
      zero_run  = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_run     = zero_run & (shadow_val[4*i +: 4] == 4'h0);
         zero_from[i] = zero_run;
      end
      // Digit 0 always shows. A digit with its point on counts as significant.
      if ((idx != '0) && zero_from[idx] && !digit_dp) begin
         seg_nxt = SEG_OFF;
         dp_nxt  = 1'b1;
      end
`endif
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of its sources.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the shadow registers are reset on purpose. After reset the
         // display shows a defined 0 and not stale data.
         ps         <= '0;
         idx        <= '0;
         shadow_val <= '0;
         shadow_dp  <= '0;
         wrap_q     <= 1'b0;
         seg        <= SEG_OFF;
         dp         <= 1'b1;
         an         <= '1;
         frame_done <= 1'b0;
      end else begin
         if (load) begin
            shadow_val <= value;
            shadow_dp  <= dp_mask;
         end
         if (en) begin
            seg        <= seg_nxt;
            dp         <= dp_nxt;
            an         <= an_nxt;
            frame_done <= wrap_q;
            if (ps == PS_LAST) begin
               ps <= '0;
               if (idx == IDX_LAST) begin
                  idx    <= '0;
                  wrap_q <= 1'b1;
               end else begin
                  idx    <= idx + 1'b1;
                  wrap_q <= 1'b0;
               end
            end else begin
               ps     <= ps + 1'b1;
               wrap_q <= 1'b0;
            end
         end else begin
            // Park the scan at the start of digit 0. Clearing wrap_q means
            // re-enabling the display never produces a stray frame_done.
            ps         <= '0;
            idx        <= '0;
            wrap_q     <= 1'b0;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            an         <= '1;
            frame_done <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Directed bench for seg7_scan_driver with DIGITS=4 and SCAN_DIV=4. Inputs
// change right after the falling edge and outputs are sampled there too.
// Each expected value comes from a segment table copied from the hex
// encoding list.
// ---------------------------------------------------------------------------
module tb_seg7_scan_driver;

   localparam int DIGITS   = 4;
   localparam int SCAN_DIV = 4;

   logic                clk;
   logic                rst;
   logic                en;
   logic                load;
   logic [4*DIGITS-1:0] value;
   logic [DIGITS-1:0]   dp_mask;
   logic [6:0]          seg;
   logic                dp;
   logic [DIGITS-1:0]   an;
   logic                frame_done;

   int checks = 0;
   int errors = 0;

   logic [6:0] hex_tab [0:15] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   seg7_scan_driver #(
      .DIGITS   (DIGITS),
      .SCAN_DIV (SCAN_DIV)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .load       (load),
      .value      (value),
      .dp_mask    (dp_mask),
      .seg        (seg),
      .dp         (dp),
      .an         (an),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_pins(input string tag, input logic [3:0] exp_an, input logic [6:0] exp_seg,
                             input logic exp_dp, input logic exp_fd);
      check({tag, ".an"},  32'(an),         32'(exp_an));
      check({tag, ".seg"}, 32'(seg),        32'(exp_seg));
      check({tag, ".dp"},  32'(dp),         32'(exp_dp));
      check({tag, ".fd"},  32'(frame_done), 32'(exp_fd));
   endtask

   function automatic logic [3:0] an_of(input int d);
      logic [3:0] one;
      one = 4'b0001;
      return ~(one << d);
   endfunction

   initial begin
      logic [3:0] nib12af [0:3];
      logic [6:0] lz_seg;
      int d;
      nib12af = '{4'hF, 4'hA, 4'h2, 4'h1};

      // Reset wins over enable and load.
      rst = 1'b1; en = 1'b1; load = 1'b1; value = 16'hFFFF; dp_mask = 4'hF;
      tick();
      tick();
      check_pins("reset", 4'b1111, 7'h7F, 1'b1, 1'b0);

      // First digit after reset shows the cleared shadow value, which is 0.
      rst = 1'b0; load = 1'b0;
      tick();
      check_pins("post_reset", 4'b1110, 7'b1000000, 1'b1, 1'b0);

      // Load 12AF with a point on digit 2 while the display is parked.
      en = 1'b0; load = 1'b1; value = 16'h12AF; dp_mask = 4'b0100;
      tick();
      check_pins("park", 4'b1111, 7'h7F, 1'b1, 1'b0);
      load = 1'b0; en = 1'b1;
      for (int k = 0; k < 32; k++) begin
         tick();
         d = (k / 4) % 4;
         check_pins($sformatf("scan%0d", k), an_of(d), hex_tab[nib12af[d]],
                    (d == 2) ? 1'b0 : 1'b1, (k == 16) ? 1'b1 : 1'b0);
      end

      // A disable right after the wrap suppresses the pending frame_done.
      en = 1'b0;
      tick();
      check_pins("dis_wrap", 4'b1111, 7'h7F, 1'b1, 1'b0);

      // Drop en in the middle of digit 2, then re-enable.
      en = 1'b1;
      for (int k = 0; k < 10; k++) tick();
      check("mid_d2.an", 32'(an), 32'(4'b1011));
      en = 1'b0;
      tick();
      check_pins("en_off", 4'b1111, 7'h7F, 1'b1, 1'b0);
      en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check_pins($sformatf("reen%0d", k), 4'b1110, 7'b0001110, 1'b1, 1'b0);
      end
      tick();
      check("reen4.an", 32'(an), 32'(4'b1101));

      // Load on the wrap edge: digit 3 keeps the old nibble, and digit 0
      // shows the new one together with frame_done.
      for (int k = 5; k < 15; k++) tick();
      load = 1'b1; value = 16'h0003; dp_mask = 4'b0000;
      tick();
      check_pins("coll_d3", 4'b0111, 7'b1111001, 1'b1, 1'b0);
      load = 1'b0;
      tick();
      check_pins("coll_d0", 4'b1110, 7'b0110000, 1'b1, 1'b1);
      tick();
      check("coll_fd_off", 32'(frame_done), 32'd0);
      for (int k = 0; k < 3; k++) tick();
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      lz_seg = 7'h7F;
`else
      lz_seg = 7'b1000000;
`endif
      check_pins("coll_d1", 4'b1101, lz_seg, 1'b1, 1'b0);

      // Synchronous reset mid-scan, together with a load that must lose.
      rst = 1'b1; load = 1'b1; value = 16'hFFFF; dp_mask = 4'hF;
      tick();
      check_pins("midreset", 4'b1111, 7'h7F, 1'b1, 1'b0);
      rst = 1'b0; load = 1'b0;
      tick();
      check_pins("midreset_d0", 4'b1110, 7'b1000000, 1'b1, 1'b0);

      // Leading zeros: 0030 (digits 3 and 2 are blanked only with the macro).
      en = 1'b0; load = 1'b1; value = 16'h0030; dp_mask = 4'b0000;
      tick();
      load = 1'b0; en = 1'b1;
      for (int k = 0; k < 16; k++) begin
         tick();
         d = k / 4;
         check($sformatf("lz%0d.an", k), 32'(an), 32'(an_of(d)));
         check($sformatf("lz%0d.seg", k), 32'(seg),
               32'((d == 0) ? 7'b1000000 : (d == 1) ? 7'b0110000 : lz_seg));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
